// File: rtl/instr_align_buffer.sv
// Halfword-granular instruction queue between fetch and decode.
// Presents a contiguous 4-halfword window at the oldest unconsumed halfword.
module instr_align_buffer #(
  parameter int unsigned           DEPTH_HW   = 16,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_valid,
  output logic                         fetch_ready,
  input  logic [63:0]                  fetch_data,
  input  logic                         flush,
  input  logic [ADDR_WIDTH-1:0]        flush_pc,
  input  logic [2:0]                   decode_consume,
  output logic                         out_valid,
  output logic [63:0]                  out_instr,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  output logic [$clog2(DEPTH_HW):0]    count
);

  localparam int unsigned PTR_W    = $clog2(DEPTH_HW);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [63:0] NOP_PAIR = 64'h00000013_00000013;

  logic [15:0]           mem_q [DEPTH_HW];
  logic [15:0]           mem_d [DEPTH_HW];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [1:0]            skip_q, skip_d;

  logic                  accept;
  logic                  consume_ok;
  logic [2:0]            fill_hw;
  logic [2:0]            take_hw;

  // Space check uses the registered count only, so a consume never frees room early.
  assign fetch_ready = (cnt_q <= CNT_W'(DEPTH_HW - 4));
  assign out_valid   = (cnt_q >= CNT_W'(4));
  assign accept      = fetch_valid && fetch_ready && !flush;
  assign consume_ok  = out_valid && (decode_consume <= 3'd4);
  assign fill_hw     = 3'd4 - {1'b0, skip_q};
  assign take_hw     = consume_ok ? decode_consume : 3'd0;

  assign out_pc = out_pc_q;
  assign count  = cnt_q;

  // The first packet after a redirect drops its halfwords below the target.
  always_comb begin
    mem_d = mem_q;
    if (accept) begin
      for (int k = 0; k < 4; k++) begin
        if (k >= int'(skip_q)) begin
          mem_d[wr_ptr_q + PTR_W'(k) - PTR_W'(skip_q)] = fetch_data[16*k +: 16];
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(take_hw);
    wr_ptr_d = accept ? (wr_ptr_q + PTR_W'(fill_hw)) : wr_ptr_q;
    skip_d   = accept ? 2'd0 : skip_q;
    cnt_d    = cnt_q + (accept ? CNT_W'(fill_hw) : CNT_W'(0)) - CNT_W'(take_hw);
    out_pc_d = out_pc_q + ADDR_WIDTH'({take_hw, 1'b0});
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      out_pc_d = flush_pc;
      skip_d   = flush_pc[2:1];
    end
  end

  // Pointer arithmetic wraps naturally because the depth is a power of two.
  always_comb begin
    out_instr = NOP_PAIR;
    if (out_valid) begin
      for (int i = 0; i < 4; i++) begin
        out_instr[16*i +: 16] = mem_q[rd_ptr_q + PTR_W'(i)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      out_pc_q <= RESET_PC;
      skip_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      out_pc_q <= out_pc_d;
      skip_q   <= skip_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/instr_align_buffer.md
Name: instr_align_buffer

Overview:
Halfword-granular instruction queue between the fetch unit and the IFID pipe register. It accepts 64-bit fetch packets and absorbs the misalignment caused by mixed 16/32-bit (compressed) instructions. It always presents decode with a contiguous 64-bit window starting at the oldest unconsumed halfword. Decode reports how many halfwords (0..4) it retired each cycle.

Parameters:
DEPTH_HW, 16, buffer depth in halfwords; power of two, >= 8
ADDR_WIDTH, 32, PC width
RESET_PC, 32'h0000_0000, out_pc value after reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
fetch_valid  in  1  fetch packet valid
fetch_ready  out  1  buffer can accept a full packet
fetch_data  in  64  packet; halfword k = bits [16k+15:16k]
flush  in  1  redirect (branch/exception); kills buffer contents
flush_pc  in  ADDR_WIDTH  redirect target, halfword aligned
decode_consume  in  3  halfwords retired this cycle (0..4)
out_valid  out  1  out_instr holds 4 valid halfwords
out_instr  out  64  window; halfword 0 = oldest
out_pc  out  ADDR_WIDTH  PC of halfword 0
count  out  log2(DEPTH_HW)+1  halfwords currently buffered

Behaviour:
- Storage: circular array of DEPTH_HW halfwords. Read pointer rd_ptr, write pointer wr_ptr, occupancy cnt. Pointers wrap modulo DEPTH_HW.
- Reset (async, rst_n=0): rd_ptr=wr_ptr=cnt=0, skip=0, out_pc=RESET_PC. Outputs: out_valid=0, fetch_ready=1, count=0.
- fetch_ready = (DEPTH_HW - cnt >= 4). It depends on the registered cnt only; a same-cycle consume does not free space early.
- Accept = fetch_valid && fetch_ready && !flush.
  - On accept, write halfwords skip..3 of fetch_data at wr_ptr onward.
  - wr_ptr advances by 4-skip; skip clears to 0.
- out_valid = (cnt >= 4).
  - When out_valid=1: out_instr = halfwords rd_ptr..rd_ptr+3, combinational from the array, with wrap handled.
  - When out_valid=0: out_instr = 64'h00000013_00000013 (two NOPs).
- Consume is legal only when out_valid=1 and decode_consume<=4. Otherwise it is treated as 0: no pointer or PC change.
- A legal consume n advances rd_ptr by n and out_pc by 2n at the clock edge.
- Same-cycle accept and consume: both take effect. cnt_next = cnt + (4-skip) - n.
- Flush has highest priority and takes effect at the clock edge:
  - rd_ptr=wr_ptr=cnt=0; out_pc=flush_pc; skip=flush_pc[2:1].
  - A fetch handshake or consume in the same cycle is discarded.
  - The next accepted packet must be the 8-byte-aligned packet containing flush_pc. Its halfwords below flush_pc[2:1] are dropped via skip.
- Registers: cnt, pointers, out_pc and skip are registered. out_valid, fetch_ready and out_instr are combinational from those registers and the array.
- Latency: a packet accepted at edge T is visible on out_instr after edge T, provided cnt>=4 at that point.
- Boundaries:
  - Full: cnt=DEPTH_HW-3..DEPTH_HW gives fetch_ready=0; cnt never exceeds DEPTH_HW.
  - Empty: out_valid=0 and NOPs are driven; cnt never goes negative.
  - Wrap: a window spanning index DEPTH_HW-1 → 0 is contiguous on out_instr.
  - out_pc wraps modulo 2^ADDR_WIDTH.
  - Reset mid-operation: immediate clear; array contents need not be cleared.

Test Plan:
- Reset, then one packet 64'h57c157c1_00000013 accepted → next cycle out_valid=1, out_instr=64'h57c157c1_00000013, out_pc=0, count=4.
- Same packet, consume=2 with no new fetch → count=2, out_valid=0, out_instr=NOPs, out_pc=4. Feed 64'h00000013_00000013 → out_instr=64'h00000013_57c157c1, out_pc=4, count=6.
- Continuous fetch, decode consuming 4,2,3,1 → pc advances 8,4,6,2; data order preserved across rd_ptr/wr_ptr wrap; count never exceeds 16.
- Stall decode (consume=0) with fetch_valid=1 → 4 accepts, count=16, fetch_ready=0. Then consume=4 → fetch_ready=1 the next cycle.
- Flush with flush_pc=32'h0000_000E plus a simultaneous fetch_valid/consume → count=0, out_pc=0xE. Next packet 64'hAAAA_BBBB_CCCC_DDDD → count=1 (only 16'hAAAA kept), out_valid=0.
- Consume=5 or consume=3 while out_valid=0 → no change to count or out_pc. Assert rst_n low mid-stream → outputs return to reset values immediately.
